// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_MAX_BURST = 4;

    // Width of an index/counter covering 0..n-1, never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/bank-side bundle for the write arbiter.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] waddr;
    logic [N_REQ*WIDTH-1:0]  wdata;
    logic [N_REQ-1:0]        gnt;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic                    busy;

    // Requesters plus the register bank.
    modport master (
        output req, lock, waddr, wdata,
        input  gnt, wr_en, wr_addr, wr_data, busy
    );

    // The arbiter.
    modport slave (
        input  req, lock, waddr, wdata,
        output gnt, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [PTR_W-1:0] idx_o
);
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    logic             found;

    // Walk the requesters starting at ptr; the first eligible one wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!found && eligible_i[cand_idx]) begin
                found              = 1'b1;
                onehot_o[cand_idx] = 1'b1;
                idx_o              = cand_idx;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port, with capped locked bursts.
//
// state | meaning
// IDLE  | no grant issued last cycle
// GRANT | single grant issued last cycle; that grantee sits out one arbitration unless it locks
// BURST | locked grantee keeps the port; burst_cnt counts its extra grants
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                reset,
    reg_write_arbiter_if.slave  bus
);
    localparam int PTR_W = ptr_w(N_REQ);
    localparam int CNT_W = ptr_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [WIDTH-1:0]  data_arr [N_REQ];
    logic [N_REQ-1:0]  last_oh, excl, eligible, pick_oh;
    logic [PTR_W-1:0]  pick_idx;
    logic              hold, cont;

    // Unflatten per-requester address/data buses.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i] = bus.waddr[i*ADDR_W +: ADDR_W];
            data_arr[i] = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    // Decide burst continuation and mask the previous grantee for one arbitration.
    always_comb begin
        last_oh         = '0;
        last_oh[last_q] = 1'b1;
        hold            = bus.req[last_q] & bus.lock[last_q];
        case (state_q)
            GRANT:   cont = hold && (MAX_BURST > 1);
            BURST:   cont = hold && (cnt_q < CNT_LAST);
            default: cont = 1'b0;
        endcase
        excl     = ((state_q != IDLE) && !cont) ? last_oh : '0;
        eligible = bus.req & ~excl;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .onehot_o   (pick_oh),
        .idx_o      (pick_idx)
    );

    // Next-state and next-output selection; ptr stays put while a burst continues.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (cont) begin
            state_d   = BURST;
            gnt_d     = last_oh;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_arr[last_q];
            wr_data_d = data_arr[last_q];
            cnt_d     = (state_q == GRANT) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end else if (|eligible) begin
            state_d   = GRANT;
            gnt_d     = pick_oh;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_arr[pick_idx];
            wr_data_d = data_arr[pick_idx];
            last_d    = pick_idx;
            ptr_d     = (pick_idx == IDX_LAST) ? '0 : pick_idx + PTR_W'(1);
            cnt_d     = '0;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // FSM and registered outputs; reset drops any in-flight grant immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one write port of the enable-gated register bank (built from the team's `dff` cells) among up to `N_REQ` requesters. Each cycle it picks one requester and drives the bank's `enable`, address and data for one clock. It returns a one-cycle grant to the winner and supports locked bursts of bounded length. It sits between the datapath/IO write sources and the register bank.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, register data width
- `ADDR_W`, 3, register address width (bank depth 2**ADDR_W)
- `MAX_BURST`, 4, max consecutive grants to one locked requester (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `req`  in  N_REQ  write request per requester
- `lock`  in  N_REQ  requester wants to keep the port for its next write
- `waddr`  in  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- `wdata`  in  N_REQ*WIDTH  flattened data, requester i at [i*WIDTH +: WIDTH]
- `gnt`  out  N_REQ  one-hot, one-cycle: write of requester i committed this cycle
- `wr_en`  out  1  bank write enable (to `dff` enables)
- `wr_addr`  out  ADDR_W  bank write address
- `wr_data`  out  WIDTH  bank write data
- `busy`  out  1  state != IDLE

## Operation
- Arbitration each cycle over `eligible = req & ~excl`. `excl` = one-hot of last grantee, except when that grantee is in an active burst.
- Round-robin: search starts at `ptr` (reg, log2 N_REQ bits), wrapping modulo N_REQ. After a grant to i, `ptr` = (i+1) mod N_REQ. During a burst, `ptr` is not advanced.
- Winner's `waddr`/`wdata` are registered onto `wr_addr`/`wr_data`. `wr_en` and `gnt[winner]` are set for exactly one cycle.
- Requester holds `req`, `waddr`, `wdata` stable until it sees `gnt[i]`. It then deasserts `req` (or presents the next write) by the following edge.
- FSM states:
  - IDLE: no grant last cycle; `eligible`≠0 → GRANT.
  - GRANT: grant issued last cycle. If the grantee had `lock[i]`=1 and `req[i]`=1, and MAX_BURST>1 → BURST with `burst_cnt`=1. Else if `eligible`≠0 → GRANT (next winner), else → IDLE.
  - BURST: the grantee keeps priority while `req[i]&lock[i]`. `burst_cnt` increments per grant.
  - Leaving BURST: when `burst_cnt`==MAX_BURST-1 at a grant, or when `lock[i]`/`req[i]` drop, the grantee is excluded for one arbitration. Then → GRANT if others eligible, else IDLE.
- No requests → `wr_en`=0, outputs `wr_addr`/`wr_data` hold last value.
- Simultaneous requests: lowest index at or after `ptr` wins.
- Single requester re-requesting without lock: granted every other cycle (exclusion slot).

## Timing
- Latency: `req` sampled at edge t → `wr_en`/`gnt` high in cycle t+1. The bank captures at edge t+2.
- Throughput: one write per cycle when ≥2 requesters are active, or during a burst.
- Reset (asynchronous, any time): `gnt`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `ptr`=0, `burst_cnt`=0, state IDLE. An in-flight write is dropped and its `gnt` is never issued.
- First arbitration happens at the first rising edge after `reset` returns to 1.

## Structure
- Package `reg_arb_pkg`: state enum (IDLE, GRANT, BURST), default parameter constants, and a `ptr`-width function.
- Sub-module `rr_pick`: combinational round-robin one-hot picker (inputs `eligible`, `ptr`; outputs one-hot and index).
- Top holds the FSM, `ptr`, `burst_cnt`, last-grantee register, and output registers.

## Test plan
- Reset: hold `reset`=0 with `req`=4'b1111 → all outputs 0, `busy`=0. Release → `gnt`=4'b0001 one cycle later, with `wr_addr`/`wr_data` equal to requester 0's values.
- Round-robin: `req`=4'b1111 held, no lock → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, `wr_en`=1 throughout.
- Single requester without lock: `req`=4'b0100 held → `gnt`=0100 on alternate cycles. `wr_en` toggles 1,0,1,0.
- Burst cap: MAX_BURST=4, `req`=4'b0011, `lock[0]`=1 → `gnt` 0001 ×4, then 0010, then 0001.
- Async reset mid-burst: drop `reset` between edges during BURST → `wr_en`/`gnt` go 0 immediately (not at the next edge). After release, `ptr`=0 and arbitration restarts at requester 0.
- Data routing: requester 3 sends `waddr`=3'd5, `wdata`=32'hDEADBEEF alone → cycle after `req`, `wr_addr`=5, `wr_data`=DEADBEEF, `gnt`=1000.
